baseram_arbiter: RTL and testbench

Sequencing controller and two-port arbiter for the board's 1M x 32 base SRAM. It shares the SRAM between the instruction-fetch port (read only) and the data port (read/write with byte enables). It generates all SRAM strobes from registered state with a parameterised access length, and returns per-port ready pulses and stall signals to the pipeline. It replaces direct combinational strobe drive of the SRAM by the fetch stage.

---
 rtl/baseram_arbiter.sv | 94 +++++++++
 tb/tb_baseram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/baseram_arbiter.sv
// baseram_arbiter: round-robin fetch/data arbiter and registered strobe sequencer for the base SRAM
module baseram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    inout  wire  [31:0] baseram_data,
    output logic [19:0] baseram_addr,
    output logic [3:0]  baseram_be_n,
    output logic        baseram_ce_n,
    output logic        baseram_oe_n,
    output logic        baseram_we_n
);
    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
    state_t state, state_d;
    logic [3:0] cnt;
    logic [31:0] wdata_q;
    logic last_grant, gnt, sel, grant, last, wr_d;
    logic ce_n_d, oe_n_d, we_n_d;
    logic [3:0] be_n_d;
    logic unused;
    assign unused = ^{if_addr[31:22], if_addr[1:0], d_addr[31:22], d_addr[1:0]};
    assign sel = (if_req && d_req) ? ~last_grant : d_req;
    assign grant = state == IDLE && (if_req || d_req);
    assign last = cnt == LAST;
    assign if_ready = state == DONE && !gnt;
    assign d_ready = state == DONE && gnt;
    assign if_stall = if_req && !if_ready;
    assign d_stall = d_req && !d_ready;
    assign baseram_data = (state inside {WR_SETUP, WR_PULSE, WR_HOLD}) ? wdata_q : 'z;
    // next state and the strobe levels that go with it
    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (grant) state_d = (sel && d_we) ? WR_SETUP : RD;
            RD:       if (last) state_d = DONE;
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: if (last) state_d = WR_HOLD;
            WR_HOLD:  state_d = DONE;
            default:  state_d = IDLE;
        endcase
        wr_d = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
        ce_n_d = !(wr_d || state_d == RD);
        oe_n_d = state_d != RD;
        we_n_d = state_d != WR_PULSE;
        be_n_d = state_d == RD ? 4'h0 : !wr_d ? 4'hF : grant ? ~d_be : baseram_be_n;
    end
    // state, strobes, grant latches and read capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            last_grant <= 1'b0;
            gnt <= 1'b0;
            wdata_q <= '0;
            baseram_addr <= '0;
            baseram_be_n <= 4'hF;
            baseram_ce_n <= 1'b1;
            baseram_oe_n <= 1'b1;
            baseram_we_n <= 1'b1;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_d;
            cnt <= (state_d == state) ? cnt + 4'd1 : 4'd0;
            baseram_be_n <= be_n_d;
            baseram_ce_n <= ce_n_d;
            baseram_oe_n <= oe_n_d;
            baseram_we_n <= we_n_d;
            if (grant) begin
                gnt <= sel;
                last_grant <= sel;
                baseram_addr <= sel ? d_addr[21:2] : if_addr[21:2];
                wdata_q <= d_wdata;
            end
            if (state == RD && last && gnt) d_rdata <= baseram_data;
            if (state == RD && last && !gnt) if_rdata <= baseram_data;
        end
    end
endmodule

// File: tb/tb_baseram_arbiter.sv
// tb_baseram_arbiter: directed table, corner sequences and random round-robin check of baseram_arbiter
module tb_baseram_arbiter;
    localparam int W = 2;
    typedef struct {
        logic        port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [19:0] ba;
        logic [3:0]  ben;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [3:0] d_be = 4'h0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata;
    logic if_ready, if_stall, d_ready, d_stall;
    wire [31:0] baseram_data;
    logic [19:0] baseram_addr;
    logic [3:0] baseram_be_n;
    logic baseram_ce_n, baseram_oe_n, baseram_we_n;

    logic [31:0] sram [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_if_rd = '0, exp_d_rd = '0;
    int total = 0, bad = 0;

    baseram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .baseram_data(baseram_data), .baseram_addr(baseram_addr), .baseram_be_n(baseram_be_n),
        .baseram_ce_n(baseram_ce_n), .baseram_oe_n(baseram_oe_n), .baseram_we_n(baseram_we_n)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return i == 2 ? 32'h1122_3344 : i == 4 ? 32'h1234_5678 : 32'h5A5A_0000 + 32'(i);
    endfunction

    assign baseram_data = (!baseram_ce_n && !baseram_oe_n) ? sram[baseram_addr[5:0]] : 'z;

    initial begin
        for (int i = 0; i < 64; i++) sram[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!baseram_ce_n && !baseram_we_n)
                for (int b = 0; b < 4; b++)
                    if (!baseram_be_n[b]) sram[baseram_addr[5:0]][8*b +: 8] = baseram_data[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("proto oe_n/we_n both low", 32'(baseram_oe_n | baseram_we_n), 1);
        chk("proto both ready", 32'(if_ready & d_ready), 0);
    endtask

    task automatic mem_write(input int w, input logic [3:0] be, input logic [31:0] wd);
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic do_reset();
        if_req = 0;
        d_req = 0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        exp_if_rd = '0;
        exp_d_rd = '0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int cyc, wel, oel;
        tick();
        chk({nm, " idle ready"}, {30'b0, if_ready, d_ready}, 0);
        if (v.port) begin
            d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1; if_addr = v.addr;
        end
        tick();
        chk({nm, " addr"}, 32'(baseram_addr), 32'(v.ba));
        chk({nm, " be_n"}, 32'(baseram_be_n), 32'(v.ben));
        chk({nm, " ce/oe/we"}, {29'b0, baseram_ce_n, baseram_oe_n, baseram_we_n}, {29'b0, 1'b0, v.we, 1'b1});
        chk({nm, " stall"}, 32'(v.port ? d_stall : if_stall), 1);
        if (v.we) chk({nm, " bus"}, baseram_data, v.wdata);
        cyc = 1;
        wel = 0;
        oel = int'(!baseram_oe_n);
        while (!if_ready && !d_ready && cyc < 60) begin
            tick();
            cyc++;
            wel += int'(!baseram_we_n);
            oel += int'(!baseram_oe_n);
        end
        chk({nm, " ready port"}, {30'b0, if_ready, d_ready}, v.port ? 32'd1 : 32'd2);
        chk({nm, " latency"}, cyc, v.we ? W + 3 : W + 1);
        chk({nm, " strobe width"}, v.we ? wel : oel, W);
        chk({nm, " stall at ready"}, 32'(v.port ? d_stall : if_stall), 0);
        if_req = 0;
        d_req = 0;
        if (v.we) mem_write(int'(v.addr[7:2]), v.be, v.wdata);
        else if (v.port) exp_d_rd = v.rd;
        else exp_if_rd = v.rd;
        chk({nm, " if_rdata"}, if_rdata, exp_if_rd);
        chk({nm, " d_rdata"}, d_rdata, exp_d_rd);
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        logic pi, pd, mlast, win, dwe;
        logic [3:0] dbe;
        logic [31:0] dwd, tmp;
        int ia, da, extra, c, expc;
        tbl[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_5678, 20'h4, 4'h0};
        tbl[1] = '{1'b1, 1'b1, 4'b0101, 32'h0000_0008, 32'hAABB_CCDD, 32'h0, 20'h2, 4'b1010};
        tbl[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0, 32'h11BB_33DD, 20'h2, 4'h0};
        tbl[3] = '{1'b1, 1'b1, 4'h0, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0, 20'h3, 4'hF};
        tbl[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_000C, 32'h0, 32'h5A5A_0003, 20'h3, 4'h0};
        tbl[5] = '{1'b0, 1'b0, 4'h0, 32'hFFC0_0008, 32'h0, 32'h11BB_33DD, 20'h2, 4'h0};
        tbl[6] = '{1'b1, 1'b1, 4'hF, 32'h0000_000C, 32'hCAFE_F00D, 32'h0, 20'h3, 4'h0};
        tbl[7] = '{1'b0, 1'b0, 4'h0, 32'h0000_000C, 32'h0, 32'hCAFE_F00D, 20'h3, 4'h0};
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);

        if_req = 1;
        d_req = 1;
        #1 rst_n = 0;
        tick();
        tick();
        chk("reset strobes", {29'b0, baseram_ce_n, baseram_oe_n, baseram_we_n}, 32'h7);
        chk("reset be_n", 32'(baseram_be_n), 32'hF);
        chk("reset addr", 32'(baseram_addr), 0);
        chk("reset ready", {30'b0, if_ready, d_ready}, 0);
        chk("reset rdata", if_rdata | d_rdata, 0);
        if_req = 0;
        d_req = 0;
        rst_n = 1;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        tick();
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h0000_00A0; d_wdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("abort we_n in pulse", 32'(baseram_we_n), 0);
        #1 rst_n = 0;
        #1 chk("abort async strobes", {30'b0, baseram_ce_n, baseram_we_n}, 3);
        d_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort no ready", 32'(d_ready), 0);
        end
        rst_n = 1;
        exp_if_rd = '0;
        exp_d_rd = '0;
        chk("abort d_rdata cleared", d_rdata, 0);
        v = '{1'b1, 1'b1, 4'hF, 32'h0000_0014, 32'h0BAD_CAFE, 32'h0, 20'h5, 4'h0};
        run_vec(v, "post-abort write");
        v = '{1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0, 32'h0BAD_CAFE, 20'h5, 4'h0};
        run_vec(v, "post-abort read");

        do_reset();
        if_req = 1; if_addr = 32'h0000_0010;
        d_req = 1; d_we = 0; d_addr = 32'h0000_0008;
        for (int k = 0; k < 4; k++) begin
            c = 0;
            do begin tick(); c++; end while (!if_ready && !d_ready && c < 60);
            chk($sformatf("alt%0d port", k), {30'b0, if_ready, d_ready}, k % 2 == 0 ? 32'd1 : 32'd2);
            chk($sformatf("alt%0d gap", k), c, k == 0 ? W + 1 : W + 2);
        end
        if_req = 0;
        d_req = 0;
        chk("alt d_rdata", d_rdata, ref_mem[2]);
        chk("alt if_rdata", if_rdata, ref_mem[4]);
        tick();
        chk("alt ready single cycle", {30'b0, if_ready, d_ready}, 0);

        do_reset();
        pi = 0; pd = 0; mlast = 0; extra = 0;
        ia = 0; da = 0; dwe = 0; dbe = 0; dwd = 0;
        for (int r = 0; r < 150; r++) begin
            if (!pd && $urandom_range(0, 1) == 1) begin
                da = $urandom_range(0, 31);
                dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom);
                dwd = $urandom;
                tmp = $urandom;
                d_addr = (tmp & 32'hFFC0_0003) | 32'(da << 2);
                d_we = dwe; d_be = dbe; d_wdata = dwd; d_req = 1; pd = 1;
            end
            if (!pi && ($urandom_range(0, 1) == 1 || !pd)) begin
                ia = $urandom_range(0, 31);
                tmp = $urandom;
                if_addr = (tmp & 32'hFFC0_0003) | 32'(ia << 2);
                if_req = 1; pi = 1;
            end
            win = (pi && pd) ? !mlast : pd;
            mlast = win;
            expc = extra + ((win && dwe) ? W + 3 : W + 1);
            extra = 1;
            c = 0;
            do begin tick(); c++; end while (!if_ready && !d_ready && c < 60);
            chk($sformatf("rand%0d port", r), {30'b0, if_ready, d_ready}, win ? 32'd1 : 32'd2);
            chk($sformatf("rand%0d latency", r), c, expc);
            if (win) begin
                if (dwe) mem_write(da, dbe, dwd);
                else exp_d_rd = ref_mem[da];
                pd = 0;
                d_req = 0;
            end else begin
                exp_if_rd = ref_mem[ia];
                pi = 0;
                if_req = 0;
            end
            chk($sformatf("rand%0d if_rdata", r), if_rdata, exp_if_rd);
            chk($sformatf("rand%0d d_rdata", r), d_rdata, exp_d_rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
